fifo_flags: RTL and testbench

- Parametrised synchronous FIFO, successor to the basic fifo/tri_state pair.
- Separate input and output data ports; no shared bidirectional bus.
- Adds an occupancy count, programmable almost-full/almost-empty flags, a registered read data-valid strobe, same-cycle read+write at full, and sticky overflow/underflow error flags.
- Sits between producer and consumer logic in the same clock domain.

---
 rtl/fifo_flags.sv | 123 ++++++++++++
 tb/tb_fifo_flags.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// flags, a registered read-valid strobe and sticky overflow/underflow errors.
module fifo_flags #(
  parameter int DATA_WIDTH      = 8,
  parameter int DATA_SIZE       = 16,
  parameter int AFULL_LEVEL     = DATA_SIZE - 2,
  parameter int AEMPTY_LEVEL    = 2,
  parameter int DATA_SIZE_WIDTH = $clog2(DATA_SIZE),
  parameter int COUNT_WIDTH     = $clog2(DATA_SIZE + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_write,
  input  logic                       en_read,
  input  logic                       clr_err,
  input  logic [DATA_WIDTH-1:0]      in,
  output logic [DATA_WIDTH-1:0]      out,
  output logic                       out_valid,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [COUNT_WIDTH-1:0]     count,
  output logic [DATA_SIZE_WIDTH-1:0] head,
  output logic [DATA_SIZE_WIDTH-1:0] tail,
  output logic                       overflow,
  output logic                       underflow
);

  localparam logic [DATA_SIZE_WIDTH-1:0] PTR_LAST   = DATA_SIZE_WIDTH'(DATA_SIZE - 1);
  localparam logic [DATA_SIZE_WIDTH-1:0] PTR_ONE    = DATA_SIZE_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0]     COUNT_MAX  = COUNT_WIDTH'(DATA_SIZE);
  localparam logic [COUNT_WIDTH-1:0]     COUNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0]     AFULL_CNT  = COUNT_WIDTH'(AFULL_LEVEL);
  localparam logic [COUNT_WIDTH-1:0]     AEMPTY_CNT = COUNT_WIDTH'(AEMPTY_LEVEL);

  logic [DATA_WIDTH-1:0]      mem [DATA_SIZE];
  logic [DATA_WIDTH-1:0]      rd_data_reg;
  logic                       rd_seen_reg;

  logic [DATA_SIZE_WIDTH-1:0] head_reg, head_next;
  logic [DATA_SIZE_WIDTH-1:0] tail_reg, tail_next;
  logic [COUNT_WIDTH-1:0]     count_reg, count_next;
  logic                       out_valid_reg;
  logic                       overflow_reg, overflow_next;
  logic                       underflow_reg, underflow_next;

  logic                       empty_w, full_w;
  logic                       wr_ok, rd_ok;

  always_comb begin
    empty_w = (count_reg == '0);
    full_w  = (count_reg == COUNT_MAX);
    rd_ok   = en_read & ~empty_w;
    // A read in the same cycle frees the slot this write needs when full.
    wr_ok   = en_write & (~full_w | rd_ok);

    head_next = head_reg;
    if (rd_ok) begin
      head_next = (head_reg == PTR_LAST) ? '0 : head_reg + PTR_ONE;
    end

    tail_next = tail_reg;
    if (wr_ok) begin
      tail_next = (tail_reg == PTR_LAST) ? '0 : tail_reg + PTR_ONE;
    end

    count_next = count_reg;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_reg + COUNT_ONE;
      2'b01:   count_next = count_reg - COUNT_ONE;
      default: count_next = count_reg;
    endcase

    // A fresh error in the clearing cycle takes priority over the clear.
    overflow_next  = (overflow_reg  & ~clr_err) | (en_write & ~wr_ok);
    underflow_next = (underflow_reg & ~clr_err) | (en_read  & ~rd_ok);
  end

  // Storage and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[tail_reg] <= in;
    end
    if (rd_ok) begin
      rd_data_reg <= mem[head_reg];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      rd_seen_reg   <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      head_reg      <= head_next;
      tail_reg      <= tail_next;
      count_reg     <= count_next;
      out_valid_reg <= rd_ok;
      rd_seen_reg   <= rd_seen_reg | rd_ok;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Until the first read after reset the RAM register is undefined; show zero.
  assign out          = rd_seen_reg ? rd_data_reg : '0;
  assign out_valid    = out_valid_reg;
  assign empty        = empty_w;
  assign full         = full_w;
  assign almost_empty = (count_reg <= AEMPTY_CNT);
  assign almost_full  = (count_reg >= AFULL_CNT);
  assign count        = count_reg;
  assign head         = head_reg;
  assign tail         = tail_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_flags.sv
// Bench for fifo_flags: a 4-entry and a 5-entry instance checked against a
// queue-based reference model, with directed scenarios and random traffic.
module tb_fifo_flags;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  // ---------------- DATA_SIZE = 4 instance ----------------
  logic       we4, re4, clr4;
  logic [7:0] din4, out4;
  logic       vld4, empty4, full4, ae4, af4, ovf4, unf4;
  logic [2:0] count4;
  logic [1:0] head4, tail4;
  logic [21:0] st4;
  assign st4 = {out4, vld4, empty4, full4, ae4, af4, count4, head4, tail4, ovf4, unf4};

  fifo_flags #(.DATA_WIDTH(8), .DATA_SIZE(4)) dut4 (
    .clk(clk), .rst(rst), .en_write(we4), .en_read(re4), .clr_err(clr4),
    .in(din4), .out(out4), .out_valid(vld4), .empty(empty4), .full(full4),
    .almost_empty(ae4), .almost_full(af4), .count(count4), .head(head4),
    .tail(tail4), .overflow(ovf4), .underflow(unf4)
  );

  // ---------------- DATA_SIZE = 5 instance ----------------
  logic       we5, re5, clr5;
  logic [7:0] din5, out5;
  logic       vld5, empty5, full5, ae5, af5, ovf5, unf5;
  logic [2:0] count5;
  logic [2:0] head5, tail5;
  logic [23:0] st5;
  assign st5 = {out5, vld5, empty5, full5, ae5, af5, count5, head5, tail5, ovf5, unf5};

  fifo_flags #(.DATA_WIDTH(8), .DATA_SIZE(5)) dut5 (
    .clk(clk), .rst(rst), .en_write(we5), .en_read(re5), .clr_err(clr5),
    .in(din5), .out(out5), .out_valid(vld5), .empty(empty5), .full(full5),
    .almost_empty(ae5), .almost_full(af5), .count(count5), .head(head5),
    .tail(tail5), .overflow(ovf5), .underflow(unf5)
  );

  // ---------------- reference models ----------------
  logic [7:0] q4[$];
  logic [7:0] q5[$];
  logic [7:0] m_out4, m_out5;
  bit m_vld4, m_ovf4, m_unf4, m_vld5, m_ovf5, m_unf5;
  int m_wr4, m_rd4, m_wr5, m_rd5;

  localparam logic [21:0] RST4 = {8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0};
  localparam logic [23:0] RST5 = {8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0};

  task automatic reset_models();
    q4.delete(); q5.delete();
    m_out4 = 8'h00; m_out5 = 8'h00;
    m_vld4 = 0; m_ovf4 = 0; m_unf4 = 0; m_vld5 = 0; m_ovf5 = 0; m_unf5 = 0;
    m_wr4 = 0; m_rd4 = 0; m_wr5 = 0; m_rd5 = 0;
  endtask

  function automatic logic [21:0] exp_state4();
    int n = q4.size();
    return {m_out4, m_vld4, n == 0, n == 4, n <= 2, n >= 2, 3'(n),
            2'(m_rd4 % 4), 2'(m_wr4 % 4), m_ovf4, m_unf4};
  endfunction

  function automatic logic [23:0] exp_state5();
    int n = q5.size();
    return {m_out5, m_vld5, n == 0, n == 5, n <= 2, n >= 3, 3'(n),
            3'(m_rd5 % 5), 3'(m_wr5 % 5), m_ovf5, m_unf5};
  endfunction

  // One clock of traffic on each instance; the model applies the accept rules.
  task automatic cycle4(input bit we, input bit re, input bit clr, input logic [7:0] d);
    bit rok, wok;
    we4 = we; re4 = re; clr4 = clr; din4 = d;
    @(posedge clk);
    rok = re && (q4.size() > 0);
    wok = we && ((q4.size() < 4) || rok);
    m_ovf4 = (m_ovf4 && !clr) || (we && !wok);
    m_unf4 = (m_unf4 && !clr) || (re && !rok);
    m_vld4 = rok;
    if (rok) begin m_out4 = q4.pop_front(); m_rd4++; end
    if (wok) begin q4.push_back(d); m_wr4++; end
    #1;
    we4 = 0; re4 = 0; clr4 = 0;
  endtask

  task automatic cycle5(input bit we, input bit re, input bit clr, input logic [7:0] d);
    bit rok, wok;
    we5 = we; re5 = re; clr5 = clr; din5 = d;
    @(posedge clk);
    rok = re && (q5.size() > 0);
    wok = we && ((q5.size() < 5) || rok);
    m_ovf5 = (m_ovf5 && !clr) || (we && !wok);
    m_unf5 = (m_unf5 && !clr) || (re && !rok);
    m_vld5 = rok;
    if (rok) begin m_out5 = q5.pop_front(); m_rd5++; end
    if (wok) begin q5.push_back(d); m_wr5++; end
    #1;
    we5 = 0; re5 = 0; clr5 = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    reset_models();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    #1;
    reset_models();
    checks++;
    if (st4 !== RST4) begin errors++; $display("FAIL reset4: got %h want %h", st4, RST4); end
    checks++;
    if (st5 !== RST5) begin errors++; $display("FAIL reset5: got %h want %h", st5, RST5); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      cycle4(1, 0, 0, 8'(8'h11 * (i + 1)));
      checks++;
      if (count4 !== 3'(i + 1)) begin errors++; $display("FAIL fill_count: got %0d want %0d", count4, i + 1); end
      checks++;
      if ({full4, af4} !== {i == 3, i >= 1}) begin
        errors++; $display("FAIL fill_flags: got full=%b af=%b want full=%b af=%b", full4, af4, i == 3, i >= 1);
      end
      $display("fill  wr=%h count=%0d full=%b af=%b", din4, count4, full4, af4);
    end
  endtask

  task automatic test_overflow();
    cycle4(1, 0, 0, 8'h55);
    checks++;
    if ({ovf4, count4} !== {1'b1, 3'd4}) begin
      errors++; $display("FAIL overflow: got ovf=%b count=%0d want ovf=1 count=4", ovf4, count4);
    end
    $display("ovfl  wr=55 ovf=%b count=%0d", ovf4, count4);
    for (int i = 0; i < 4; i++) begin
      cycle4(0, 1, 0, 8'h00);
      checks++;
      if ({vld4, out4} !== {1'b1, 8'(8'h11 * (i + 1))}) begin
        errors++; $display("FAIL drain_out: got vld=%b out=%h want vld=1 out=%h", vld4, out4, 8'(8'h11 * (i + 1)));
      end
      $display("drain out=%h vld=%b count=%0d", out4, vld4, count4);
    end
    cycle4(0, 0, 1, 8'h00);
    checks++;
    if ({empty4, vld4, out4, ovf4} !== {1'b1, 1'b0, 8'h44, 1'b0}) begin
      errors++; $display("FAIL clr_ovf: got empty=%b vld=%b out=%h ovf=%b want 1 0 44 0", empty4, vld4, out4, ovf4);
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 4; i++) cycle4(1, 0, 0, 8'(8'h11 * (i + 1)));
    for (int i = 0; i < 4; i++) begin
      cycle4(1, 1, 0, 8'(8'h66 + i));
      checks++;
      if ({out4, count4, head4, tail4} !== {8'(8'h11 * (i + 1)), 3'd4, 2'((i + 1) % 4), 2'((i + 1) % 4)}) begin
        errors++; $display("FAIL full_rw: got out=%h count=%0d head=%0d tail=%0d", out4, count4, head4, tail4);
      end
      checks++;
      if (st4 !== exp_state4()) begin errors++; $display("FAIL full_rw_state: got %h want %h", st4, exp_state4()); end
      $display("fullrw wr=%h out=%h count=%0d head=%0d tail=%0d", din4, out4, count4, head4, tail4);
    end
  endtask

  task automatic test_empty_rw();
    for (int i = 0; i < 4; i++) begin
      cycle4(0, 1, 0, 8'h00);
      checks++;
      if (out4 !== 8'(8'h66 + i)) begin errors++; $display("FAIL drain2: got %h want %h", out4, 8'(8'h66 + i)); end
    end
    cycle4(1, 1, 0, 8'h77);
    checks++;
    if ({unf4, vld4, count4} !== {1'b1, 1'b0, 3'd1}) begin
      errors++; $display("FAIL empty_rw: got unf=%b vld=%b count=%0d want 1 0 1", unf4, vld4, count4);
    end
    $display("emptyrw wr=77 unf=%b vld=%b count=%0d", unf4, vld4, count4);
    cycle4(0, 1, 0, 8'h00);
    checks++;
    if ({vld4, out4} !== {1'b1, 8'h77}) begin errors++; $display("FAIL no_fallthru: got vld=%b out=%h want 1 77", vld4, out4); end
    cycle4(0, 1, 1, 8'h00);
    checks++;
    if (unf4 !== 1'b1) begin errors++; $display("FAIL clr_vs_err: got unf=%b want 1", unf4); end
    cycle4(0, 0, 1, 8'h00);
    checks++;
    if (unf4 !== 1'b0) begin errors++; $display("FAIL clr_unf: got unf=%b want 0", unf4); end
    $display("clrerr unf=%b", unf4);
  endtask

  task automatic test_wrap5();
    logic [7:0] d;
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      cycle5(1, 0, 0, d);
      checks++;
      if ({head5, tail5} !== {3'(i % 5), 3'((i + 1) % 5)}) begin
        errors++; $display("FAIL wrap5_wr: got head=%0d tail=%0d want %0d %0d", head5, tail5, i % 5, (i + 1) % 5);
      end
      cycle5(0, 1, 0, 8'h00);
      checks++;
      if ({out5, vld5, head5} !== {d, 1'b1, 3'((i + 1) % 5)}) begin
        errors++; $display("FAIL wrap5_rd: got out=%h vld=%b head=%0d want %h 1 %0d", out5, vld5, head5, d, (i + 1) % 5);
      end
      $display("wrap5 pair=%0d data=%h head=%0d tail=%0d", i, out5, head5, tail5);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 250; i++) begin
      cycle4($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, 8'($urandom));
      checks++;
      if (st4 !== exp_state4()) begin errors++; $display("FAIL rand4 #%0d: got %h want %h", i, st4, exp_state4()); end
      $display("rand4 #%0d count=%0d out=%h vld=%b ovf=%b unf=%b", i, count4, out4, vld4, ovf4, unf4);
    end
    for (int i = 0; i < 250; i++) begin
      cycle5($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, 8'($urandom));
      checks++;
      if (st5 !== exp_state5()) begin errors++; $display("FAIL rand5 #%0d: got %h want %h", i, st5, exp_state5()); end
      $display("rand5 #%0d count=%0d out=%h vld=%b ovf=%b unf=%b", i, count5, out5, vld5, ovf5, unf5);
    end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      cycle4(1, 0, 0, 8'(8'hA0 + i));
      cycle5(1, 0, 0, 8'(8'hB0 + i));
    end
    cycle4(0, 1, 0, 8'h00);
    cycle4(1, 0, 0, 8'hA3);
    checks++;
    if ({count4, count5} !== {3'd3, 3'd3}) begin errors++; $display("FAIL pre_rst: got %0d %0d want 3 3", count4, count5); end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    reset_models();
    checks++;
    if (st4 !== RST4) begin errors++; $display("FAIL mid_rst4: got %h want %h", st4, RST4); end
    checks++;
    if (st5 !== RST5) begin errors++; $display("FAIL mid_rst5: got %h want %h", st5, RST5); end
    $display("midrst count4=%0d count5=%0d empty4=%b", count4, count5, empty4);
    @(negedge clk);
    rst = 1'b1;
    cycle4(0, 1, 0, 8'h00);
    checks++;
    if ({unf4, vld4, count4} !== {1'b1, 1'b0, 3'd0}) begin
      errors++; $display("FAIL post_rst_rd: got unf=%b vld=%b count=%0d want 1 0 0", unf4, vld4, count4);
    end
    checks++;
    if (st4 !== exp_state4()) begin errors++; $display("FAIL post_rst_state: got %h want %h", st4, exp_state4()); end
  endtask

  initial begin
    we4 = 0; re4 = 0; clr4 = 0; din4 = 0;
    we5 = 0; re5 = 0; clr5 = 0; din5 = 0;
    test_reset();
    test_fill();
    test_overflow();
    test_full_rw();
    test_empty_rw();
    test_wrap5();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
